// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with load-use hazard detection,
//                branch/jump flush and saturating stall/flush event counters.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset                 clock, asynchronous active-high reset
//    id_*                       decoded instruction presented by ID
//    ex_flush                   branch/jump taken in EX, kill ID instruction
//    ex_*                       registered fields presented to EX
//    stall                      combinational: freeze PC and IF/ID
//    stall_count, flush_count   saturating debug event counters
// ============================================================================
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic             id_alusrc,
    input  logic             id_branch,
    input  logic [1:0]       id_aluop,
    input  logic             ex_flush,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_memtoreg,
    output logic             ex_alusrc,
    output logic             ex_branch,
    output logic [1:0]       ex_aluop,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            alusrc;
        logic            branch;
        logic [1:0]      aluop;
    } ex_t;

    ex_t              ex_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_luse;

    // A load currently in EX whose destination is read by the ID instruction.
    // x0 never creates a dependency.
    always_comb begin
        w_rs1_hit = id_uses_rs1 && (id_rs1 == ex_q.rd);
        w_rs2_hit = id_uses_rs2 && (id_rs2 == ex_q.rd);
        w_luse    = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0)
                    && (w_rs1_hit || w_rs2_hit);
    end

    // A flush discards the ID instruction, so there is nothing to hold.
    assign stall = w_luse && !ex_flush;

    always_comb begin
        ex_d        = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (ex_flush) begin
            // Bubble; only count flushes that actually killed an instruction.
            if (id_valid && (flush_cnt_q != C_CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + C_CNT_ONE;
            end
        end else if (w_luse) begin
            // Bubble; ID is held upstream and re-presented next cycle.
            if (stall_cnt_q != C_CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + C_CNT_ONE;
            end
        end else begin
            ex_d.valid    = id_valid;
            ex_d.pc       = id_pc;
            ex_d.rs1_data = id_rs1_data;
            ex_d.rs2_data = id_rs2_data;
            ex_d.imm      = id_imm;
            // Control, opcode-modifier and address fields of an invalid slot
            // stay zero so downstream hazard/forwarding logic never matches.
            if (id_valid) begin
                ex_d.rs1      = id_rs1;
                ex_d.rs2      = id_rs2;
                ex_d.rd       = id_rd;
                ex_d.funct3   = id_funct3;
                ex_d.funct7b5 = id_funct7b5;
                ex_d.regwrite = id_regwrite;
                ex_d.memread  = id_memread;
                ex_d.memwrite = id_memwrite;
                ex_d.memtoreg = id_memtoreg;
                ex_d.alusrc   = id_alusrc;
                ex_d.branch   = id_branch;
                ex_d.aluop    = id_aluop;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_pc       = ex_q.pc;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_funct3   = ex_q.funct3;
    assign ex_funct7b5 = ex_q.funct7b5;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_memtoreg = ex_q.memtoreg;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_branch   = ex_q.branch;
    assign ex_aluop    = ex_q.aluop;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage against a behavioural
//                pipeline-slot model; a second, narrow-counter instance
//                exercises counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int XL    = 32;
    localparam int SMALL = 4;

    typedef struct packed {
        logic          valid;
        logic [XL-1:0] pc, rs1d, rs2d, imm;
        logic [4:0]    rs1, rs2, rd;
        logic          u1, u2;
        logic [2:0]    f3;
        logic          f7;
        logic          rw, mr, mw, mtr, as, br;
        logic [1:0]    aluop;
    } id_t;

    typedef struct packed {
        logic          valid;
        logic [XL-1:0] pc, rs1d, rs2d, imm;
        logic [4:0]    rs1, rs2, rd;
        logic [2:0]    f3;
        logic          f7;
        logic          rw, mr, mw, mtr, as, br;
        logic [1:0]    aluop;
    } ex_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    id_t  id    = '0;

    logic          ex_valid, ex_funct7b5, ex_regwrite, ex_memread, ex_memwrite;
    logic          ex_memtoreg, ex_alusrc, ex_branch, stall;
    logic [XL-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]    ex_rs1, ex_rs2, ex_rd;
    logic [2:0]    ex_funct3;
    logic [1:0]    ex_aluop;
    logic [15:0]   stall_count, flush_count;

    logic          s_valid, s_funct7b5, s_regwrite, s_memread, s_memwrite;
    logic          s_memtoreg, s_alusrc, s_branch, s_stall;
    logic [XL-1:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
    logic [4:0]    s_rs1, s_rs2, s_rd;
    logic [2:0]    s_funct3;
    logic [1:0]    s_aluop;
    logic [SMALL-1:0] s_stall_count, s_flush_count;

    ex_t dut_ex, small_ex;
    assign dut_ex = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
                     ex_rd, ex_funct3, ex_funct7b5, ex_regwrite, ex_memread, ex_memwrite,
                     ex_memtoreg, ex_alusrc, ex_branch, ex_aluop};
    assign small_ex = {s_valid, s_pc, s_rs1_data, s_rs2_data, s_imm, s_rs1, s_rs2,
                       s_rd, s_funct3, s_funct7b5, s_regwrite, s_memread, s_memwrite,
                       s_memtoreg, s_alusrc, s_branch, s_aluop};

    id_ex_stage #(.XLEN(XL), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .id_valid(id.valid), .id_pc(id.pc),
        .id_rs1_data(id.rs1d), .id_rs2_data(id.rs2d), .id_imm(id.imm),
        .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
        .id_uses_rs1(id.u1), .id_uses_rs2(id.u2), .id_funct3(id.f3),
        .id_funct7b5(id.f7), .id_regwrite(id.rw), .id_memread(id.mr),
        .id_memwrite(id.mw), .id_memtoreg(id.mtr), .id_alusrc(id.as),
        .id_branch(id.br), .id_aluop(id.aluop), .ex_flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
        .ex_aluop(ex_aluop), .stall(stall), .stall_count(stall_count),
        .flush_count(flush_count)
    );

    id_ex_stage #(.XLEN(XL), .CNT_W(SMALL)) u_dut_small (
        .clk(clk), .reset(reset), .id_valid(id.valid), .id_pc(id.pc),
        .id_rs1_data(id.rs1d), .id_rs2_data(id.rs2d), .id_imm(id.imm),
        .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
        .id_uses_rs1(id.u1), .id_uses_rs2(id.u2), .id_funct3(id.f3),
        .id_funct7b5(id.f7), .id_regwrite(id.rw), .id_memread(id.mr),
        .id_memwrite(id.mw), .id_memtoreg(id.mtr), .id_alusrc(id.as),
        .id_branch(id.br), .id_aluop(id.aluop), .ex_flush(flush),
        .ex_valid(s_valid), .ex_pc(s_pc), .ex_rs1_data(s_rs1_data),
        .ex_rs2_data(s_rs2_data), .ex_imm(s_imm), .ex_rs1(s_rs1),
        .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct3(s_funct3),
        .ex_funct7b5(s_funct7b5), .ex_regwrite(s_regwrite),
        .ex_memread(s_memread), .ex_memwrite(s_memwrite),
        .ex_memtoreg(s_memtoreg), .ex_alusrc(s_alusrc), .ex_branch(s_branch),
        .ex_aluop(s_aluop), .stall(s_stall), .stall_count(s_stall_count),
        .flush_count(s_flush_count)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    ex_t  m_ex   = '0;
    int   m_stall = 0;
    int   m_flush = 0;

    // Reference: a load sitting in EX blocks any valid ID instruction that
    // reads its (non-zero) destination register.
    function automatic logic model_hazard(ex_t cur, id_t d);
        logic reads;
        reads = (d.u1 && d.rs1 == cur.rd) || (d.u2 && d.rs2 == cur.rd);
        return d.valid && cur.valid && cur.mr && (cur.rd != 5'd0) && reads;
    endfunction

    // Reference: contents of the EX slot after one clock.
    function automatic ex_t model_next(ex_t cur, id_t d, logic fl);
        ex_t n;
        n = '0;
        if (fl || model_hazard(cur, d)) return n;
        n.valid = d.valid;
        n.pc = d.pc; n.rs1d = d.rs1d; n.rs2d = d.rs2d; n.imm = d.imm;
        if (d.valid) begin
            n.rs1 = d.rs1; n.rs2 = d.rs2; n.rd = d.rd; n.f3 = d.f3; n.f7 = d.f7;
            n.rw = d.rw; n.mr = d.mr; n.mw = d.mw; n.mtr = d.mtr; n.as = d.as;
            n.br = d.br; n.aluop = d.aluop;
        end
        return n;
    endfunction

    function automatic int sat(int v, int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Advance one clock, entering and leaving 1 time unit after a rising edge.
    // Returns the stall observed shortly before the edge and the model's view.
    task automatic tick(output logic st_seen, output logic st_exp);
        logic hz;
        #2;
        hz      = model_hazard(m_ex, id);
        st_seen = stall;
        st_exp  = hz && !flush;
        @(posedge clk);
        if (flush) begin
            if (id.valid) m_flush++;
        end else if (hz) begin
            m_stall++;
        end
        m_ex = model_next(m_ex, id, flush);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        id    = '0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_ex    = '0;
        m_stall = 0;
        m_flush = 0;
    endtask

    function automatic id_t mk_load(logic [4:0] rd, logic [4:0] rs1);
        id_t d;
        d = '0;
        d.valid = 1'b1; d.pc = 32'h100; d.rd = rd; d.rs1 = rs1; d.u1 = 1'b1;
        d.mr = 1'b1; d.rw = 1'b1; d.mtr = 1'b1; d.as = 1'b1; d.f3 = 3'b010;
        d.imm = 32'h4;
        return d;
    endfunction

    function automatic id_t mk_alu(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                   logic u1, logic u2);
        id_t d;
        d = '0;
        d.valid = 1'b1; d.pc = 32'h104; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2;
        d.u1 = u1; d.u2 = u2; d.rw = 1'b1; d.aluop = 2'b10;
        d.rs1d = 32'hAAAA_0001; d.rs2d = 32'h5555_0002;
        return d;
    endfunction

    task automatic test_reset();
        logic ss, se;
        reset = 1'b1;
        id = mk_alu(5'd9, 5'd1, 5'd2, 1'b1, 1'b1);
        id.pc = $urandom;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_ex !== '0 || stall !== 1'b0 || stall_count !== 16'd0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: ex=%h stall=%b sc=%0d fc=%0d required all zero",
                     dut_ex, stall, stall_count, flush_count);
        end
        reset = 1'b0;
        m_ex = '0; m_stall = 0; m_flush = 0;
        id = '0;
        id.valid = 1'b1; id.rd = 5'd5; id.rw = 1'b1;
        tick(ss, se);
        checks++;
        if (ex_rd !== 5'd5 || ex_regwrite !== 1'b1 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_capture: rd=%0d rw=%b v=%b required 5 1 1",
                     ex_rd, ex_regwrite, ex_valid);
        end
    endtask

    task automatic test_load_use();
        logic ss, se;
        do_reset();
        id = mk_load(5'd5, 5'd1);
        tick(ss, se);
        id = mk_alu(5'd6, 5'd5, 5'd7, 1'b1, 1'b1);
        tick(ss, se);
        checks++;
        if (ss !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: stall=%b required 1", ss);
        end
        checks++;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || stall_count !== 16'd1) begin
            errors++;
            $display("FAIL load_use_bubble: v=%b rw=%b sc=%0d required 0 0 1",
                     ex_valid, ex_regwrite, stall_count);
        end
        tick(ss, se);
        checks++;
        if (ss !== 1'b0 || ex_rs1 !== 5'd5 || dut_ex !== m_ex) begin
            errors++;
            $display("FAIL load_use_release: stall=%b rs1=%0d ex=%h required 0 5 %h",
                     ss, ex_rs1, dut_ex, m_ex);
        end
    endtask

    task automatic test_no_hazard();
        logic ss, se;
        do_reset();
        id = mk_load(5'd5, 5'd1);
        tick(ss, se);
        id = mk_alu(5'd6, 5'd3, 5'd5, 1'b1, 1'b0);
        tick(ss, se);
        checks++;
        if (ss !== 1'b0 || dut_ex !== m_ex) begin
            errors++;
            $display("FAIL no_hazard_rs2_unused: stall=%b ex=%h required 0 %h", ss, dut_ex, m_ex);
        end
        id = mk_load(5'd0, 5'd1);
        tick(ss, se);
        id = mk_alu(5'd6, 5'd0, 5'd0, 1'b1, 1'b1);
        tick(ss, se);
        checks++;
        if (ss !== 1'b0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL no_hazard_x0: stall=%b sc=%0d required 0 0", ss, stall_count);
        end
    endtask

    task automatic test_flush_priority();
        logic ss, se;
        do_reset();
        id = mk_load(5'd5, 5'd1);
        tick(ss, se);
        id = mk_alu(5'd6, 5'd5, 5'd7, 1'b1, 1'b1);
        flush = 1'b1;
        tick(ss, se);
        flush = 1'b0;
        checks++;
        if (ss !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority_stall: stall=%b required 0", ss);
        end
        checks++;
        if (dut_ex !== '0 || flush_count !== 16'd1 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL flush_priority_bubble: ex=%h fc=%0d sc=%0d required 0 1 0",
                     dut_ex, flush_count, stall_count);
        end
    endtask

    task automatic test_back_to_back();
        logic ss, se;
        int   nst;
        do_reset();
        nst = 0;
        id = mk_load(5'd5, 5'd1);
        tick(ss, se);
        id = mk_load(5'd6, 5'd5);
        tick(ss, se); nst += int'(ss);
        tick(ss, se); nst += int'(ss);
        id = mk_alu(5'd7, 5'd6, 5'd2, 1'b1, 1'b1);
        tick(ss, se); nst += int'(ss);
        tick(ss, se); nst += int'(ss);
        checks++;
        if (nst != 2 || stall_count !== 16'd2 || dut_ex !== m_ex) begin
            errors++;
            $display("FAIL back_to_back: stalls=%0d sc=%0d ex=%h required 2 2 %h",
                     nst, stall_count, dut_ex, m_ex);
        end
    endtask

    task automatic test_random();
        logic ss, se, prev;
        logic [4:0] prev_rd;
        do_reset();
        prev = 1'b0;
        prev_rd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!prev) begin
                id.valid = ($urandom_range(0, 3) != 0);
                id.pc = $urandom; id.rs1d = $urandom; id.rs2d = $urandom; id.imm = $urandom;
                id.rs1 = 5'($urandom_range(0, 3));
                id.rs2 = 5'($urandom_range(0, 3));
                id.rd  = 5'($urandom_range(0, 3));
                id.u1 = 1'($urandom); id.u2 = 1'($urandom);
                id.f3 = 3'($urandom); id.f7 = 1'($urandom);
                id.rw = 1'($urandom); id.mr = 1'($urandom); id.mw = 1'($urandom);
                id.mtr = 1'($urandom); id.as = 1'($urandom); id.br = 1'($urandom);
                id.aluop = 2'($urandom);
            end
            flush = ($urandom_range(0, 7) == 0);
            if (prev) begin
                checks++;
                if (stall === 1'b1 && ex_rd === prev_rd) begin
                    errors++;
                    $display("FAIL rand_double_stall: cycle %0d rd=%0d", i, ex_rd);
                end
            end
            prev_rd = ex_rd;
            tick(ss, se);
            prev = se;
            checks++;
            if (ss !== se) begin
                errors++;
                $display("FAIL rand_stall: cycle %0d stall=%b required %b", i, ss, se);
            end
            checks++;
            if (dut_ex !== m_ex || small_ex !== m_ex) begin
                errors++;
                $display("FAIL rand_ex: cycle %0d ex=%h small=%h required %h", i, dut_ex, small_ex, m_ex);
            end
            checks++;
            if (stall_count !== 16'(m_stall) || flush_count !== 16'(m_flush)
                || s_stall_count !== SMALL'(sat(m_stall, SMALL))
                || s_flush_count !== SMALL'(sat(m_flush, SMALL))) begin
                errors++;
                $display("FAIL rand_counters: cycle %0d sc=%0d fc=%0d ssc=%0d sfc=%0d required %0d %0d %0d %0d",
                         i, stall_count, flush_count, s_stall_count, s_flush_count,
                         m_stall, m_flush, sat(m_stall, SMALL), sat(m_flush, SMALL));
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_saturation();
        logic ss, se;
        do_reset();
        id = mk_load(5'd5, 5'd5);
        // Load reading its own destination: alternates capture / stall.
        for (int ev = 1; ev <= 20; ev++) begin
            tick(ss, se);
            tick(ss, se);
            checks++;
            if (s_stall_count !== SMALL'(sat(ev, SMALL)) || stall_count !== 16'(ev)) begin
                errors++;
                $display("FAIL stall_saturation: event %0d small=%0d wide=%0d required %0d %0d",
                         ev, s_stall_count, stall_count, sat(ev, SMALL), ev);
            end
        end
        flush = 1'b1;
        for (int ev = 1; ev <= 20; ev++) begin
            tick(ss, se);
            checks++;
            if (s_flush_count !== SMALL'(sat(ev, SMALL)) || flush_count !== 16'(ev)) begin
                errors++;
                $display("FAIL flush_saturation: event %0d small=%0d wide=%0d required %0d %0d",
                         ev, s_flush_count, flush_count, sat(ev, SMALL), ev);
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        logic ss, se;
        do_reset();
        id = mk_load(5'd5, 5'd1);
        tick(ss, se);
        id = mk_alu(5'd6, 5'd5, 5'd7, 1'b1, 1'b0);
        #2;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_setup: stall=%b required 1", stall);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ex_memread !== 1'b0 || stall !== 1'b0 || ex_valid !== 1'b0 || ex_rd !== 5'd0) begin
            errors++;
            $display("FAIL async_reset_clear: mr=%b stall=%b v=%b rd=%0d required 0 0 0 0",
                     ex_memread, stall, ex_valid, ex_rd);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ex = '0; m_stall = 0; m_flush = 0;
        id = '0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_flush_priority();
        test_back_to_back();
        test_random();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
